// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_pkg
// Description : Shared types and constants for the branch resolution slice.
//               Holds the in-flight entry layout, instruction size and
//               performance counter width, plus a saturating increment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package branch_pkg;

  // Bytes per instruction: the fall-through address is pc + INSTR_BYTES
  localparam int INSTR_BYTES = 4;

  // Width of the performance counters
  localparam int COUNTER_W   = 32;

  // Address width of the canonical entry layout
  localparam int DEF_ADDR_W  = 32;

  // One tracked branch: where it lives, where it goes if taken, and what
  // decode guessed
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] pc;
    logic [DEF_ADDR_W-1:0] target;
    logic                  pred;
  } entry_t;

  // Counter increment that sticks at all-ones instead of wrapping
  function automatic logic [COUNTER_W-1:0] sat_inc(input logic [COUNTER_W-1:0] v);
    logic [COUNTER_W-1:0] one;
    one = {{(COUNTER_W-1){1'b0}}, 1'b1};
    return (v == {COUNTER_W{1'b1}}) ? v : v + one;
  endfunction

endpackage : branch_pkg
`default_nettype wire

// File: rtl/branch_inflight_fifo.sv
`default_nettype none
// ============================================================================
// Module      : branch_inflight_fifo
// Description : In-order queue of unresolved branches. Push at the tail, pop
//               the head, or clear the whole queue in one cycle (clear wins
//               over push/pop). Head data is read combinationally.
// Ports       : clk, rst_n          - clock, async active-low reset
//               push, pop, clear    - queue operations
//               wr_entry            - data written on push
//               head                - oldest entry (undefined when empty)
//               count, full, empty  - occupancy after the most recent edge
// Revision    : 1.0 - initial release
// ============================================================================
module branch_inflight_fifo
  import branch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type ENTRY_T = entry_t,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  ENTRY_T           wr_entry,
  output ENTRY_T           head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam logic [PTR_W-1:0] C_PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_DEPTH   = CNT_W'(DEPTH);

  ENTRY_T           r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_push;
  logic             w_pop;

  // Guard against overflow/underflow locally so the pointers can never
  // drift out of step with the count, whatever the caller does.
  assign w_push = push && !full;
  assign w_pop  = pop  && !empty;

  assign full   = (r_count == C_DEPTH);
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign head   = r_mem[r_rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_CNT_ONE;
        2'b01:   r_count <= r_count - C_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only ever read after it was written.
  always_ff @(posedge clk) begin
    if (w_push && !clear) begin
      r_mem[r_wr_ptr] <= wr_entry;
    end
  end

endmodule : branch_inflight_fifo
`default_nettype wire

// File: rtl/branch_resolver.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolver
// Description : Tracks conditional branches from decode to resolution and
//               compares each prediction with the real outcome. Mispredicts
//               raise a one-cycle flush with the corrected fetch address and
//               empty the tracking queue; every resolution sends a training
//               update to the predictor. Saturating performance counters.
// Ports       : clk, rst_n                     - clock, async active-low reset
//               dec_valid/pred_taken/pc/target - branch leaving decode
//               res_valid, res_taken           - head branch resolves
//               stall_out                      - queue full, decode holds
//               flush, redirect_pc             - mispredict recovery strobe
//               upd_valid/pc/taken             - predictor training strobe
//               branch_cnt, mispredict_cnt     - saturating counters
//               err_underflow                  - sticky: resolve when empty
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolver
  import branch_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dec_valid,
  input  logic                 dec_pred_taken,
  input  logic [ADDR_W-1:0]    dec_pc,
  input  logic [ADDR_W-1:0]    dec_target,
  input  logic                 res_valid,
  input  logic                 res_taken,
  output logic                 stall_out,
  output logic                 flush,
  output logic [ADDR_W-1:0]    redirect_pc,
  output logic                 upd_valid,
  output logic [ADDR_W-1:0]    upd_pc,
  output logic                 upd_taken,
  output logic [COUNTER_W-1:0] branch_cnt,
  output logic [COUNTER_W-1:0] mispredict_cnt,
  output logic                 err_underflow
);

  localparam int                CNT_W     = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0]  C_DEPTH   = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] C_PC_STEP = ADDR_W'(INSTR_BYTES);

  // Entry layout sized to this instance's address width
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] target;
    logic              pred;
  } inflight_t;

  inflight_t         w_wr_entry;
  inflight_t         w_head;
  logic [CNT_W-1:0]  w_count;
  logic              w_full;
  logic              w_empty;

  logic              w_res_fire;
  logic              w_mispred;
  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] w_fallthrough;
  logic [ADDR_W-1:0] w_redirect;

  // --------------------------------------------------------------------------
  // Resolution and enqueue decisions
  // --------------------------------------------------------------------------
  // Resolution always looks at the head present before the edge, so a branch
  // pushed in the same cycle can never be the one resolved.
  assign w_res_fire = res_valid && !w_empty;
  assign w_mispred  = w_res_fire && (res_taken != w_head.pred);

  // A mispredict empties the queue; anything decoded alongside it is on the
  // wrong path and is dropped rather than pushed.
  assign w_push     = dec_valid && !w_full && !w_mispred;
  assign w_pop      = w_res_fire && !w_mispred;

  assign stall_out  = (w_count == C_DEPTH);

  assign w_wr_entry = '{pc: dec_pc, target: dec_target, pred: dec_pred_taken};

  // Fall-through wraps modulo 2^ADDR_W by construction of the adder width
  assign w_fallthrough = w_head.pc + C_PC_STEP;
  assign w_redirect    = res_taken ? w_head.target : w_fallthrough;

  branch_inflight_fifo #(
    .DEPTH   (DEPTH),
    .ENTRY_T (inflight_t)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (w_push),
    .pop      (w_pop),
    .clear    (w_mispred),
    .wr_entry (w_wr_entry),
    .head     (w_head),
    .count    (w_count),
    .full     (w_full),
    .empty    (w_empty)
  );

  // --------------------------------------------------------------------------
  // Registered strobes, payloads and counters
  // --------------------------------------------------------------------------
  // Payload registers only load when their strobe fires, so they hold the
  // last value in between.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush          <= 1'b0;
      redirect_pc    <= '0;
      upd_valid      <= 1'b0;
      upd_pc         <= '0;
      upd_taken      <= 1'b0;
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
      err_underflow  <= 1'b0;
    end else begin
      flush     <= w_mispred;
      upd_valid <= w_res_fire;

      if (w_res_fire) begin
        upd_pc     <= w_head.pc;
        upd_taken  <= res_taken;
        branch_cnt <= sat_inc(branch_cnt);
      end

      if (w_mispred) begin
        redirect_pc    <= w_redirect;
        mispredict_cnt <= sat_inc(mispredict_cnt);
      end

      if (res_valid && w_empty) begin
        err_underflow <= 1'b1;
      end
    end
  end

endmodule : branch_resolver
`default_nettype wire

// File: tb/tb_branch_resolver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_branch_resolver
// Description : Self-checking bench for branch_resolver. A reference queue
//               model predicts every resolution; expected strobes are pushed
//               to a scoreboard when res_valid is driven and popped when the
//               DUT output is due.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolver;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              dec_valid = 1'b0;
  logic              dec_pred_taken = 1'b0;
  logic [ADDR_W-1:0] dec_pc = '0;
  logic [ADDR_W-1:0] dec_target = '0;
  logic              res_valid = 1'b0;
  logic              res_taken = 1'b0;
  logic              stall_out;
  logic              flush;
  logic [ADDR_W-1:0] redirect_pc;
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_taken;
  logic [31:0]       branch_cnt;
  logic [31:0]       mispredict_cnt;
  logic              err_underflow;

  always #5 clk = ~clk;

  branch_resolver #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .dec_valid      (dec_valid),
    .dec_pred_taken (dec_pred_taken),
    .dec_pc         (dec_pc),
    .dec_target     (dec_target),
    .res_valid      (res_valid),
    .res_taken      (res_taken),
    .stall_out      (stall_out),
    .flush          (flush),
    .redirect_pc    (redirect_pc),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .branch_cnt     (branch_cnt),
    .mispredict_cnt (mispredict_cnt),
    .err_underflow  (err_underflow)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] target;
    logic        pred;
  } ment_t;

  typedef struct {
    logic        valid;
    logic        flush;
    logic [31:0] redirect;
    logic [31:0] pc;
    logic        taken;
    logic [31:0] bcnt;
    logic [31:0] mcnt;
  } exp_t;

  ment_t       model_q[$];
  exp_t        exp_q[$];
  logic [31:0] m_bcnt = '0;
  logic [31:0] m_mcnt = '0;
  logic        m_under = 1'b0;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One cycle of stimulus; the model resolves on the pre-edge queue, then
  // enqueues unless the queue was full or a mispredict squashed it.
  task automatic cycle(input logic dv, input logic [31:0] pc, input logic [31:0] tgt,
                       input logic pred, input logic rv, input logic rt);
    exp_t  e;
    ment_t h;
    ment_t n;
    logic  mis;
    int    pre_size;
    mis = 1'b0;
    e   = '{default: '0};
    @(negedge clk);
    dec_valid = dv; dec_pc = pc; dec_target = tgt; dec_pred_taken = pred;
    res_valid = rv; res_taken = rt;
    pre_size = model_q.size();
    #1;
    chk("stall_out", stall_out, (pre_size == DEPTH));
    if (rv) begin
      if (pre_size == 0) begin
        m_under = 1'b1;
      end else begin
        h = model_q.pop_front();
        mis        = (rt != h.pred);
        e.valid    = 1'b1;
        e.flush    = mis;
        e.pc       = h.pc;
        e.taken    = rt;
        e.redirect = rt ? h.target : h.pc + 32'd4;
        if (m_bcnt != 32'hFFFF_FFFF) m_bcnt++;
        if (mis && m_mcnt != 32'hFFFF_FFFF) m_mcnt++;
        if (mis) model_q.delete();
      end
      e.bcnt = m_bcnt;
      e.mcnt = m_mcnt;
      exp_q.push_back(e);
    end
    if (dv && pre_size < DEPTH && !mis) begin
      n.pc = pc; n.target = tgt; n.pred = pred;
      model_q.push_back(n);
    end
    @(posedge clk);
  endtask

  task automatic idle();
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    dec_valid = 1'b0; res_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_flush",      flush, 0);
    chk("rst_redirect",   redirect_pc, 0);
    chk("rst_upd_valid",  upd_valid, 0);
    chk("rst_upd_pc",     upd_pc, 0);
    chk("rst_upd_taken",  upd_taken, 0);
    chk("rst_branch_cnt", branch_cnt, 0);
    chk("rst_mis_cnt",    mispredict_cnt, 0);
    chk("rst_underflow",  err_underflow, 0);
    chk("rst_stall",      stall_out, 0);
    model_q.delete();
    exp_q.delete();
    m_bcnt = '0; m_mcnt = '0; m_under = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Output monitor: compares the strobes one cycle after each sampled edge
  always @(posedge clk) begin
    logic s;
    exp_t e;
    s = res_valid && rst_n;
    #1;
    if (s) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_underrun", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("upd_valid", upd_valid, e.valid);
        chk("flush", flush, e.flush);
        if (e.valid) begin
          chk("upd_pc", upd_pc, e.pc);
          chk("upd_taken", upd_taken, e.taken);
        end
        if (e.flush) chk("redirect_pc", redirect_pc, e.redirect);
        chk("branch_cnt", branch_cnt, e.bcnt);
        chk("mispredict_cnt", mispredict_cnt, e.mcnt);
        chk("err_underflow", err_underflow, m_under);
      end
    end else begin
      chk("idle_upd_valid", upd_valid, 0);
      chk("idle_flush", flush, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();

    // Taken branch predicted not-taken -> redirect to target
    cycle(1'b1, 32'h100, 32'h140, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0,   32'h0,   1'b0, 1'b1, 1'b1);
    idle();
    chk("t1_redirect", redirect_pc, 32'h140);
    chk("t1_mis_cnt", mispredict_cnt, 1);

    // Not-taken branch predicted taken -> fall-through, including wrap
    cycle(1'b1, 32'h200, 32'h280, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 32'h0,   32'h0,   1'b0, 1'b1, 1'b0);
    cycle(1'b1, 32'hFFFF_FFFC, 32'h10, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 32'h0,   32'h0,   1'b0, 1'b1, 1'b0);
    idle();
    chk("t2_redirect_wrap", redirect_pc, 32'h0);
    chk("t2_redirect_hold", redirect_pc, 32'h0);

    // Fill to capacity, 5th branch ignored, drain with correct predictions
    do_reset();
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b1, 32'h300 + 32'(i * 8), 32'h400 + 32'(i * 8), 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'h500, 32'h600, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
    idle();
    chk("t3_branch_cnt", branch_cnt, 4);
    chk("t3_mis_cnt", mispredict_cnt, 0);
    chk("t3_stall_clear", stall_out, 0);

    // Back-to-back enqueue plus correct resolve in the same cycle
    cycle(1'b1, 32'h700, 32'h780, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'h704 + 32'(i * 4), 32'h790, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    idle();

    // Head mispredicts alongside a new decode: queue cleared, new one dropped
    do_reset();
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'h800 + 32'(i * 4), 32'h880, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h900, 32'h980, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 32'h0,   32'h0,   1'b0, 1'b1, 1'b0);
    idle();
    chk("t4_underflow", err_underflow, 1);
    chk("t4_stall", stall_out, 0);

    // Reset mid-flight with two entries queued and branch_cnt=5
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 32'hA00 + 32'(i * 4), 32'hB00, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
    end
    cycle(1'b1, 32'hC00, 32'hC80, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hC04, 32'hC80, 1'b0, 1'b0, 1'b0);
    idle();
    chk("t5_branch_cnt", branch_cnt, 5);
    do_reset();
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    idle();
    chk("t5_empty_after_reset", err_underflow, 1);

    // Saturation of branch_cnt
    do_reset();
    force dut.branch_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.branch_cnt;
    m_bcnt = 32'hFFFF_FFFF;
    cycle(1'b1, 32'hD00, 32'hD40, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 32'h0,   32'h0,   1'b0, 1'b1, 1'b1);
    idle();
    chk("t6_branch_cnt_sat", branch_cnt, 32'hFFFF_FFFF);

    idle();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_branch_resolver
`default_nettype wire

// File: doc/branch_resolver.md
# branch_resolver

Tracks every conditional branch from decode to memory stage and checks the prediction made at decode against the real outcome. Sits beside the branch predictor: it receives each prediction as the branch issues and the actual decision at resolution. On a mismatch it issues a flush and a corrected fetch address, and on every resolution it sends a training update back to the predictor. It also keeps branch and misprediction counters for performance evaluation.

## Interface
- DEPTH, 4: maximum number of in-flight unresolved branches (power of two, ≥2)
- ADDR_W, 32: address width
- clk  in  1  clock, all state updates on posedge
- rst_n  in  1  reset is asynchronous and active-low
- dec_valid  in  1  a branch leaves decode this cycle
- dec_pred_taken  in  1  prediction issued for that branch
- dec_pc  in  ADDR_W  branch instruction address
- dec_target  in  ADDR_W  computed taken target (pc + offset)
- res_valid  in  1  oldest in-flight branch resolves this cycle
- res_taken  in  1  actual branch decision
- stall_out  out  1  tracking queue full, decode must hold the branch
- flush  out  1  one-cycle pulse: squash younger instructions
- redirect_pc  out  ADDR_W  corrected fetch address, valid with flush
- upd_valid  out  1  one-cycle pulse: predictor training update
- upd_pc  out  ADDR_W  address of the resolved branch
- upd_taken  out  1  actual outcome for training
- branch_cnt  out  32  resolved branches, saturating
- mispredict_cnt  out  32  mispredicted branches, saturating
- err_underflow  out  1  sticky: res_valid arrived with the queue empty

## Operation
- In-order FIFO of entries {pc, target, pred}. Capacity is DEPTH.
- Enqueue when dec_valid && !stall_out. If dec_valid is asserted while stall_out is high, the branch is ignored and no state changes.
- stall_out is combinational and equals (count == DEPTH).
- Resolution takes the head entry present before the edge. A branch enqueued in the same cycle is never the one being resolved.
- On resolution:
  - pop the head entry
  - upd_valid=1, upd_pc=head.pc, upd_taken=res_taken
  - branch_cnt increments by 1
- Mispredict occurs when res_taken != head.pred. On a mispredict:
  - flush=1
  - mispredict_cnt increments by 1
  - redirect_pc = res_taken ? head.target : head.pc + 4. Addition is modulo 2^ADDR_W, so pc 0xFFFFFFFC wraps to 0.
  - the whole queue is cleared, because all younger branches are on the wrong path
  - a dec_valid in the same cycle is discarded
- res_valid with an empty queue: err_underflow is set until reset, and there is no flush, no update and no counter change.
- Simultaneous enqueue and a correct resolution: count is unchanged and pointers advance together. This is only legal when !stall_out.
- Counters stick at 0xFFFFFFFF and do not wrap.
- Reset values:
  - queue empty, pointers 0, count 0
  - all outputs 0, both counters 0, err_underflow 0
  - reset asserted mid-flight discards all entries immediately

## Timing
- Enqueue latency: an entry accepted at edge N can be resolved by res_valid sampled at edge N+1 or later.
- flush, redirect_pc, upd_valid, upd_pc and upd_taken are registered. They are high for exactly one cycle after the edge that samples res_valid.
- redirect_pc and upd_pc hold their last value when not strobed.
- stall_out reflects count after the most recent edge, with zero-cycle combinational delay.
- Counters update on the same edge as the corresponding strobes and are visible one cycle after res_valid.
- Back-to-back res_valid on consecutive cycles is supported, giving one resolution per cycle.

## Structure
- Shared package branch_pkg holds:
  - entry typedef {pc, target, pred}
  - INSTR_BYTES = 4
  - COUNTER_W = 32
- Sub-module branch_inflight_fifo provides:
  - inputs push, pop, clear and the entry data
  - head entry, count and full outputs
  - async active-low reset
- The top level holds the compare logic, redirect computation, strobes and counters.

## Test plan
- Reset, then enqueue pc=0x100, target=0x140, pred=0, then res_taken=1 → one cycle later flush=1, redirect_pc=0x140, upd_pc=0x100, upd_taken=1, mispredict_cnt=1.
- Enqueue pc=0x200 with pred=1, resolve with res_taken=0 → redirect_pc=0x204. Enqueue pc=0xFFFFFFFC with pred=1, resolve with res_taken=0 → redirect_pc=0x0.
- Enqueue 4 correctly predicted branches → stall_out=1 and a 5th dec_valid is ignored. Resolve all 4 → no flush, branch_cnt=4, mispredict_cnt=0, stall_out=0.
- With 3 branches queued, the head mispredicts in the same cycle as a new dec_valid → count=0, the new branch is discarded, and the next res_valid sets err_underflow=1 with no upd_valid.
- Assert rst_n=0 with 2 entries queued and branch_cnt=5 → all outputs and counters read 0 and the queue is empty. Force branch_cnt to 0xFFFFFFFF, then resolve once → it holds at 0xFFFFFFFF.
